// File: rtl/uart_frame_pkg.sv
// Shared defaults, derived widths and the assembly FSM state type for the
// UART frame assembler.
package uart_frame_pkg;

   localparam int DBITS_DEF          = 8;
   localparam int FRAME_BYTES_DEF    = 16;
   localparam int TIMEOUT_CYCLES_DEF = 1_033_400;
   localparam int CNT_W_DEF          = $clog2(FRAME_BYTES_DEF + 1);

   typedef enum logic {
      FILL = 1'b0,
      WAIT = 1'b1
   } asm_state_e;

endpackage

// File: rtl/uart_frame_assembler_timer.sv
// Loadable down-counter for the inter-byte timeout; expire pulses on the
// enabled cycle that finds the count exhausted. Used only with UART_FRAME_TIMEOUT_EN.
module frame_timeout_timer #(
   parameter int unsigned LOAD_VALUE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int W = (LOAD_VALUE > 0) ? $clog2(LOAD_VALUE + 1) : 1;

   logic [W-1:0] remain_q;
   logic [W-1:0] remain_d;

   // Clear takes priority so an arriving byte always beats the expiry.
   assign expire = enable && !clear && (remain_q == '0);

   always_comb begin
      remain_d = remain_q;
      if (clear || expire) begin
         remain_d = W'(LOAD_VALUE);
      end else if (enable) begin
         remain_d = remain_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         remain_q <= W'(LOAD_VALUE);
      end else begin
         remain_q <= remain_d;
      end
   end

endmodule

// File: rtl/uart_frame_assembler.sv
// Packs FRAME_BYTES UART characters into one double-buffered frame with a
// valid/ready output. Optional stale-frame flush: define UART_FRAME_TIMEOUT_EN.
module uart_frame_assembler
   import uart_frame_pkg::*;
#(
   parameter int DBITS          = DBITS_DEF,
   parameter int FRAME_BYTES    = FRAME_BYTES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               rx_byte_valid,
   input  logic [DBITS-1:0]                   rx_byte,
   output logic [FRAME_BYTES*DBITS-1:0]       frame,
   output logic                               frame_valid,
   input  logic                               frame_ready,
   output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_count,
   output logic                               overrun,
   output logic                               timeout_flush
);

   localparam int FW    = FRAME_BYTES * DBITS;
   localparam int CNT_W = $clog2(FRAME_BYTES + 1);
   localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(FRAME_BYTES - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_BYTES);

   asm_state_e       state_q,   state_d;
   logic [CNT_W-1:0] count_q,   count_d;
   logic [FW-1:0]    asm_q,     asm_d;
   logic [FW-1:0]    frame_q,   frame_d;
   logic             valid_q,   valid_d;
   logic             overrun_q, overrun_d;
   logic             flush_q,   flush_d;

   logic [FW-1:0]    asm_written;
   logic             handshake;
   logic             out_free;
   logic             expire;

   assign handshake = valid_q && frame_ready;
   assign out_free  = !valid_q || handshake;

   // asm with the incoming byte dropped into the lane selected by count_q.
   for (genvar gi = 0; gi < FRAME_BYTES; gi++) begin : g_lane
      assign asm_written[gi*DBITS +: DBITS] =
         (count_q == CNT_W'(gi)) ? rx_byte : asm_q[gi*DBITS +: DBITS];
   end

`ifdef UART_FRAME_TIMEOUT_EN
   logic tmr_clear;
   logic tmr_enable;

   assign tmr_clear  = rx_byte_valid || (count_q == '0) || (state_q == WAIT);
   assign tmr_enable = (state_q == FILL);

   frame_timeout_timer #(
      .LOAD_VALUE (TIMEOUT_CYCLES - 1)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmr_clear),
      .enable (tmr_enable),
      .expire (expire)
   );
`else
   assign expire = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      asm_d     = asm_q;
      frame_d   = frame_q;
      valid_d   = valid_q && !handshake;
      overrun_d = overrun_q;
      flush_d   = 1'b0;

      case (state_q)
         FILL: begin
            if (rx_byte_valid) begin
               asm_d = asm_written;
               if (count_q == LAST_LANE) begin
                  if (out_free) begin
                     frame_d = asm_written;
                     valid_d = 1'b1;
                     count_d = '0;
                  end else begin
                     count_d = FULL_CNT;
                     state_d = WAIT;
                  end
               end else begin
                  count_d = count_q + CNT_W'(1);
               end
            end else if (expire) begin
               count_d = '0;
               flush_d = 1'b1;
            end
         end
         WAIT: begin
            if (handshake) begin
               frame_d = asm_q;
               valid_d = 1'b1;
               state_d = FILL;
               if (rx_byte_valid) begin
                  asm_d   = {asm_q[FW-1:DBITS], rx_byte};
                  count_d = CNT_W'(1);
               end else begin
                  count_d = '0;
               end
            end else if (rx_byte_valid) begin
               overrun_d = 1'b1;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FILL;
         count_q   <= '0;
         asm_q     <= '0;
         frame_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         flush_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         asm_q     <= asm_d;
         frame_q   <= frame_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         flush_q   <= flush_d;
      end
   end

   assign frame         = frame_q;
   assign frame_valid   = valid_q;
   assign byte_count    = count_q;
   assign overrun       = overrun_q;
   assign timeout_flush = flush_q;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler with a frame scoreboard; the timeout
// section follows UART_FRAME_TIMEOUT_EN.
module tb_uart_frame_assembler;

   localparam int DB = 8;
   localparam int FB = 16;
   localparam int TO = 40;
   localparam int FW = DB * FB;
   localparam int CW = $clog2(FB + 1);

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_byte_valid;
   logic [DB-1:0] rx_byte;
   logic [FW-1:0] frame;
   logic          frame_valid;
   logic          frame_ready;
   logic [CW-1:0] byte_count;
   logic          overrun;
   logic          timeout_flush;

   int n_assert    = 0;
   int n_fail      = 0;
   int frames_seen = 0;
   int n_pushed    = 0;
   logic [FW-1:0] exp_q[$];

   always #5 clk = ~clk;

   uart_frame_assembler #(
      .DBITS          (DB),
      .FRAME_BYTES    (FB),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_byte_valid (rx_byte_valid),
      .rx_byte       (rx_byte),
      .frame         (frame),
      .frame_valid   (frame_valid),
      .frame_ready   (frame_ready),
      .byte_count    (byte_count),
      .overrun       (overrun),
      .timeout_flush (timeout_flush)
   );

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [FW-1:0] seq_frame(input logic [7:0] s);
      logic [FW-1:0] f;
      f = '0;
      for (int k = 0; k < FB; k++) f[k*DB +: DB] = s + 8'(k);
      return f;
   endfunction

   task automatic push_frame(input logic [FW-1:0] f);
      exp_q.push_back(f);
      n_pushed++;
   endtask

   task automatic cyc(input logic v, input logic [7:0] b, input logic rdy);
      rx_byte_valid = v;
      rx_byte       = b;
      frame_ready   = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic send_seq(input logic [7:0] s, input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(1'b1, s + 8'(i), rdy);
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy);
   endtask

   // Scoreboard: every accepted frame must match the oldest expected one.
   always @(negedge clk) begin
      if (!reset && frame_valid && frame_ready) begin
         frames_seen++;
         if (exp_q.size() == 0) check("frame_unexpected", FW'(exp_q.size()), FW'(1));
         else                   check("frame_data", frame, exp_q.pop_front());
      end
   end

   initial begin
      int flush_hits;
      int frames_before;

      reset         = 1'b1;
      rx_byte_valid = 1'b0;
      rx_byte       = '0;
      frame_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_frame", frame, '0);
      check("rst_valid", FW'(frame_valid), FW'(0));
      check("rst_count", FW'(byte_count), FW'(0));
      check("rst_overrun", FW'(overrun), FW'(0));
      check("rst_flush", FW'(timeout_flush), FW'(0));
      reset = 1'b0;

      // Back-to-back bytes with the consumer always ready.
      push_frame(seq_frame(8'h00));
      send_seq(8'h00, 3, 1'b1);
      check("t1_count3", FW'(byte_count), FW'(3));
      send_seq(8'h03, 12, 1'b1);
      check("t1_valid_before_last", FW'(frame_valid), FW'(0));
      check("t1_count15", FW'(byte_count), FW'(15));
      send_seq(8'h0F, 1, 1'b1);
      check("t1_valid", FW'(frame_valid), FW'(1));
      check("t1_lane0", FW'(frame[7:0]), FW'(8'h00));
      check("t1_lane15", FW'(frame[127:120]), FW'(8'h0F));
      check("t1_count0", FW'(byte_count), FW'(0));
      idle(1, 1'b1);
      check("t1_valid_clears", FW'(frame_valid), FW'(0));

      // Consumer stalled: fill both buffers, then overrun.
      push_frame(seq_frame(8'h00));
      push_frame(seq_frame(8'h10));
      send_seq(8'h00, 16, 1'b0);
      check("t2_valid", FW'(frame_valid), FW'(1));
      check("t2_frame_a", frame, seq_frame(8'h00));
      send_seq(8'h10, 16, 1'b0);
      check("t2_frame_held", frame, seq_frame(8'h00));
      check("t2_wait_count", FW'(byte_count), FW'(16));
      check("t2_no_overrun", FW'(overrun), FW'(0));
      cyc(1'b1, 8'hAA, 1'b0);
      check("t2_overrun", FW'(overrun), FW'(1));
      check("t2_count_after_drop", FW'(byte_count), FW'(16));
      check("t2_frame_after_drop", frame, seq_frame(8'h00));
      cyc(1'b0, 8'h00, 1'b1);
      check("t2_valid_b", FW'(frame_valid), FW'(1));
      check("t2_frame_b", frame, seq_frame(8'h10));
      check("t2_count_b", FW'(byte_count), FW'(0));

      // Handshake and a new byte in the same WAIT cycle.
      push_frame(seq_frame(8'h20));
      send_seq(8'h20, 16, 1'b0);
      check("t3_wait_count", FW'(byte_count), FW'(16));
      cyc(1'b1, 8'h55, 1'b1);
      check("t3_count1", FW'(byte_count), FW'(1));
      check("t3_frame_c", frame, seq_frame(8'h20));
      push_frame(seq_frame(8'h55));
      send_seq(8'h56, 15, 1'b1);
      check("t3_valid_d", FW'(frame_valid), FW'(1));
      check("t3_lane0_d", FW'(frame[7:0]), FW'(8'h55));
      check("t3_count_d", FW'(byte_count), FW'(0));
      idle(1, 1'b1);
      check("t3_overrun_sticky", FW'(overrun), FW'(1));

      // Reset in the middle of a frame.
      send_seq(8'hB0, 7, 1'b1);
      check("t5_count7", FW'(byte_count), FW'(7));
      reset = 1'b1;
      cyc(1'b0, 8'h00, 1'b1);
      reset = 1'b0;
      check("t5_frame", frame, '0);
      check("t5_valid", FW'(frame_valid), FW'(0));
      check("t5_count", FW'(byte_count), FW'(0));
      check("t5_overrun", FW'(overrun), FW'(0));
      check("t5_flush", FW'(timeout_flush), FW'(0));
      frames_before = frames_seen;
      push_frame(seq_frame(8'hA0));
      send_seq(8'hA0, 16, 1'b1);
      idle(2, 1'b1);
      check("t5_one_frame", FW'(frames_seen - frames_before), FW'(1));

`ifdef UART_FRAME_TIMEOUT_EN
      send_seq(8'h70, 5, 1'b1);
      idle(TO - 1, 1'b1);
      check("t4_no_flush_yet", FW'(timeout_flush), FW'(0));
      check("t4_count5", FW'(byte_count), FW'(5));
      idle(1, 1'b1);
      check("t4_flush", FW'(timeout_flush), FW'(1));
      check("t4_count0", FW'(byte_count), FW'(0));
      idle(1, 1'b1);
      check("t4_flush_pulse", FW'(timeout_flush), FW'(0));
      push_frame(seq_frame(8'h80));
      send_seq(8'h80, 1, 1'b1);
      idle(TO - 1, 1'b1);
      send_seq(8'h81, 1, 1'b1);
      check("t4_byte_wins_flush", FW'(timeout_flush), FW'(0));
      check("t4_byte_wins_count", FW'(byte_count), FW'(2));
      send_seq(8'h82, 14, 1'b1);
      idle(2, 1'b1);
`else
      send_seq(8'h90, 5, 1'b1);
      flush_hits = 0;
      for (int i = 0; i < 10 * TO; i++) begin
         cyc(1'b0, 8'h00, 1'b1);
         if (timeout_flush) flush_hits++;
      end
      check("t6_no_flush", FW'(flush_hits), FW'(0));
      check("t6_count_kept", FW'(byte_count), FW'(5));
      push_frame(seq_frame(8'h90));
      send_seq(8'h95, 11, 1'b1);
      idle(2, 1'b1);
`endif

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("scoreboard_drained", FW'(exp_q.size()), FW'(0));
      check("frame_total", FW'(frames_seen), FW'(n_pushed));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
